serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2 to 32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The module SHALL have port in_1, input, WIDTH bits: minuend, sampled on the accepted start.
REQ-006 The module SHALL have port in_2, input, WIDTH bits: subtrahend, sampled on the accepted start.
REQ-007 The module SHALL have port Bin, input, 1 bit: borrow-in for bit 0, sampled on the accepted start.
REQ-008 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The module SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-010 The module SHALL have port Diff, output, WIDTH bits: the registered difference.
REQ-011 The module SHALL have port Borrow, output, 1 bit: the registered final borrow-out.

Function
REQ-012 The module SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE with start=1 at a clock edge, the module SHALL load in_1, in_2 and Bin into internal shift/borrow registers, clear the bit counter and enter RUN; this edge is the accepted start.
REQ-014 In IDLE with start=0, the module SHALL remain in IDLE.
REQ-015 In RUN, the module SHALL process one bit per clock, LSB first, with a 1-bit full subtractor: d = a XOR b XOR bin; bout = (~a AND b) OR (~(a XOR b) AND bin).
REQ-016 In RUN, the module SHALL shift d into the result register and register bout as bin for the next bit.
REQ-017 After exactly WIDTH RUN cycles, the module SHALL enter DONE.
REQ-018 On entry to DONE, Diff SHALL equal (in_1 - in_2 - Bin) mod 2^WIDTH.
REQ-019 On entry to DONE, Borrow SHALL be 1 if and only if in_1 < in_2 + Bin (unsigned).
REQ-020 done SHALL be high for exactly the one cycle spent in DONE; the next state is always IDLE.
REQ-021 Latency: done SHALL be high in the cycle beginning WIDTH+1 clock edges after the accepted start edge.
REQ-022 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-023 start SHALL be ignored while busy=1; it SHALL not alter the operands or the timing of the operation in progress.
REQ-024 start held high continuously SHALL cause back-to-back operations, with each new start accepted in the IDLE cycle following DONE.
REQ-025 Diff and Borrow SHALL hold their last result until the next DONE entry; they may change only on the DONE-entry edge.
REQ-026 in_1, in_2 and Bin SHALL be don't-care in every cycle except at the accepted start edge.

Reset
REQ-027 On rst_n=0, the module SHALL enter IDLE immediately, independent of clk.
REQ-028 During reset, busy=0, done=0, Diff=0, Borrow=0, and the internal bit counter and shift/borrow registers SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation without producing a done pulse.
REQ-030 The first start accepted after reset deassertion SHALL behave as a fresh operation.

Verification
REQ-031 The bench SHALL cover, with WIDTH=8: in_1=0x05, in_2=0x03, Bin=0 -> done 9 edges after start, Diff=0x02, Borrow=0.
REQ-032 The bench SHALL cover: in_1=0x03, in_2=0x05, Bin=0 -> Diff=0xFE, Borrow=1.
REQ-033 The bench SHALL cover: in_1=0x00, in_2=0x00, Bin=1 -> Diff=0xFF, Borrow=1; and in_1=0xFF, in_2=0x00, Bin=0 -> Diff=0xFF, Borrow=0.
REQ-034 The bench SHALL cover: start pulsed again 3 cycles into RUN with different operands -> result still reflects the first operands; exactly one done pulse.
REQ-035 The bench SHALL cover: rst_n pulled low at RUN bit 4 -> busy=0, Diff=0, no done; a subsequent 0x10-0x01 -> Diff=0x0F, Borrow=0.
REQ-036 The bench SHALL cover: start held high for 40 cycles -> done every 10 cycles, busy low for exactly 1 cycle between operations.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor bit per clock, LSB first.
// Result and final borrow are registered on the edge that enters DONE.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             bin_r;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;
    logic             last;

    assign d       = a_sr[0] ^ b_sr[0] ^ bin_r;
    assign bout    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bin_r);
    assign res_nxt = {d, res_sr[WIDTH-1:1]};
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Final bit's difference and borrow go straight into the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bin_r  <= 1'b0;
            cnt    <= '0;
            Diff   <= '0;
            Borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= in_1;
                        b_sr   <= in_2;
                        bin_r  <= Bin;
                        res_sr <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    bin_r  <= bout;
                    res_sr <= res_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        Diff   <= res_nxt;
                        Borrow <= bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected results are
// queued at each accepted start and compared on every done pulse.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in_1 = '0;
    logic [W-1:0] in_2 = '0;
    logic         Bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Borrow;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in_1   (in_1),
        .in_2   (in_2),
        .Bin    (Bin),
        .busy   (busy),
        .done   (done),
        .Diff   (Diff),
        .Borrow (Borrow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
    } exp_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           done_cnt = 0;
    logic [W-1:0] last_diff = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic bi);
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        model.diff   = r[W-1:0];
        model.borrow = r[W];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("diff", Diff, e.diff);
                chk("borrow", Borrow, e.borrow);
                last_diff = e.diff;
            end
        end
    end

    // Latency counts edges from the accepting edge (edge 1) to the DONE edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1;
        in_1  = a;
        in_2  = b;
        Bin   = bi;
        sb.push_back(model(a, b, bi));
        @(negedge clk);
        start = 1'b0;
        in_1  = W'($urandom);
        in_2  = W'($urandom);
        Bin   = 1'($urandom);
        lat   = 1;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_hold"}, Diff, last_diff);
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 9);
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int prev;
        int idle_cnt;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", Diff, 0);
        chk("rst_borrow", Borrow, 0);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, 1'b0, "c05_03");
        run_op(8'h03, 8'h05, 1'b0, "c03_05");
        run_op(8'h00, 8'h00, 1'b1, "c00_00_b");
        run_op(8'hFF, 8'h00, 1'b0, "cFF_00");
        for (int i = 0; i < 5; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), "rnd");

        // start pulsed mid-RUN with other operands must be ignored
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        in_1  = 8'h5A;
        in_2  = 8'h33;
        Bin   = 1'b1;
        sb.push_back(model(8'h5A, 8'h33, 1'b1));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        in_1  = 8'hC3;
        in_2  = 8'h11;
        Bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("ign_done_cnt", done_cnt - d0, 1);
        chk("ign_idle", busy, 0);

        // reset in the middle of an operation aborts it
        @(negedge clk);
        start = 1'b1;
        in_1  = 8'h77;
        in_2  = 8'h22;
        Bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", Diff, 0);
        chk("abort_borrow", Borrow, 0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        last_diff = '0;
        rst_n = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, "c10_01");

        // start held high: accepts on cycles 0, 10, 20, 30
        d0 = done_cnt;
        prev = -1;
        idle_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            start = 1'b1;
            in_1  = W'(i * 7 + 3);
            in_2  = W'(i * 5);
            Bin   = 1'(i & 1);
            if (i % 10 == 0) sb.push_back(model(in_1, in_2, Bin));
            @(negedge clk);
            if (done) begin
                if (prev >= 0) chk("b2b_interval", i - prev, 10);
                else chk("b2b_first", i, 8);
                prev = i;
            end
            if (!busy) begin
                idle_cnt++;
                chk("b2b_idle_after_done", i - prev, 1);
            end
        end
        start = 1'b0;
        chk("b2b_done_cnt", done_cnt - d0, 4);
        chk("b2b_idle_cnt", idle_cnt, 4);
        repeat (3) @(negedge clk);
        chk("b2b_end_idle", busy, 0);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
